// File: rtl/conv_encoder_k3.sv
// Rate-1/2 K=3 convolutional encoder (g1=111, g2=101), 14-slot framed serial output.
// Optional per-frame bit-error injection when ERR_INJ_EN is defined.
module conv_encoder_k3 #(
    parameter int INFO_W = 5,
    parameter int TAIL_W = 2
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic [INFO_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              err_inject,
    input  logic [3:0]        err_pos,
    output logic              coded_bit,
    output logic              frame_sync,
    output logic              frame_valid
);

    localparam int FRAME_L = 2 * (INFO_W + TAIL_W);
    localparam int SW      = $clog2(FRAME_L);
    localparam logic [SW-1:0] LAST = SW'(FRAME_L - 1);

    logic [SW-1:0]     slot_q, slot_d;
    logic [1:0]        sr_q, sr_d;
    logic [INFO_W-1:0] fw_q, fw_d;
    logic [INFO_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              fv_q, fv_d;
    logic              coded_q, coded_d;
    logic              sync_q, sync_d;
    logic              last, accept, u_q;

    // Info bit for a slot's step; tail steps carry zero.
    function automatic logic u_of(input logic [SW-1:0] s,
                                  input logic [INFO_W-1:0] w);
        logic u;
        int   k;
        u = 1'b0;
        k = int'(s >> 1);
        for (int i = 0; i < INFO_W; i++) begin
            if (i == k) u = w[i];
        end
        return u;
    endfunction

    function automatic logic enc_bit(input logic [SW-1:0] s,
                                     input logic [INFO_W-1:0] w,
                                     input logic [1:0] sr);
        logic u;
        u = u_of(s, w);
        return s[0] ? (u ^ sr[1]) : (u ^ sr[0] ^ sr[1]);
    endfunction

`ifdef ERR_INJ_EN
    logic       hold_err_q, hold_err_d;
    logic [3:0] hold_pos_q, hold_pos_d;
    logic       fw_err_q, fw_err_d;
    logic [3:0] fw_pos_q, fw_pos_d;
`else
    logic unused_err;
    assign unused_err = ^{err_inject, err_pos};
`endif

    assign din_ready   = ~hold_full_q;
    assign coded_bit   = coded_q;
    assign frame_sync  = sync_q;
    assign frame_valid = fv_q;

    always_comb begin
        last        = (slot_q == LAST);
        slot_d      = last ? '0 : slot_q + 1'b1;
        accept      = din_valid & din_ready;
        u_q         = u_of(slot_q, fw_q);
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        fw_d        = fw_q;
        fv_d        = fv_q;
        sr_d        = sr_q;
`ifdef ERR_INJ_EN
        hold_err_d  = hold_err_q;
        hold_pos_d  = hold_pos_q;
        fw_err_d    = fw_err_q;
        fw_pos_d    = fw_pos_q;
`endif
        if (last) begin
            sr_d        = '0;
            fw_d        = hold_full_q ? hold_q : '0;
            fv_d        = hold_full_q;
            hold_full_d = 1'b0;
`ifdef ERR_INJ_EN
            fw_err_d    = hold_full_q & hold_err_q;
            fw_pos_d    = hold_pos_q;
`endif
        end else if (slot_q[0]) begin
            // sr = {s2, s1}: shift the step's info bit in
            sr_d = {sr_q[0], u_q};
        end
        if (accept) begin
            hold_d      = din;
            hold_full_d = 1'b1;
`ifdef ERR_INJ_EN
            hold_err_d  = err_inject;
            hold_pos_d  = err_pos;
`endif
        end
        sync_d  = (slot_d == '0);
        coded_d = enc_bit(slot_d, fw_d, sr_d);
`ifdef ERR_INJ_EN
        if (fw_err_d && (int'(slot_d) == int'(fw_pos_d))) coded_d = ~coded_d;
`endif
    end

    always_ff @(posedge clk1) begin
        if (!reset) begin
            slot_q      <= '0;
            sr_q        <= '0;
            fw_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            fv_q        <= 1'b0;
            coded_q     <= 1'b0;
            sync_q      <= 1'b1;
`ifdef ERR_INJ_EN
            hold_err_q  <= 1'b0;
            hold_pos_q  <= '0;
            fw_err_q    <= 1'b0;
            fw_pos_q    <= '0;
`endif
        end else begin
            slot_q      <= slot_d;
            sr_q        <= sr_d;
            fw_q        <= fw_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            fv_q        <= fv_d;
            coded_q     <= coded_d;
            sync_q      <= sync_d;
`ifdef ERR_INJ_EN
            hold_err_q  <= hold_err_d;
            hold_pos_q  <= hold_pos_d;
            fw_err_q    <= fw_err_d;
            fw_pos_q    <= fw_pos_d;
`endif
        end
    end

endmodule
